adder_tree_arbiter: RTL and testbench

ADDER_TREE_ARBITER -- requirements
Module: adder_tree_arbiter

---
 rtl/adder_tree_pkg.sv | 18 +
 rtl/adder_tree_add8.sv | 25 ++
 rtl/adder_tree_arbiter.sv | 119 +++++++++++
 tb/tb_adder_tree_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants and helpers for the round-robin arbitrated 8-operand adder tree.
package adder_tree_pkg;

  localparam int unsigned DEF_ADDER_WIDTH = 5;
  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned OPS_PER_REQ     = 8;
  // Summing eight operands needs log2(8) extra carry bits.
  localparam int unsigned SUM_GROWTH      = 3;

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned sum_width(input int unsigned w);
    return w + SUM_GROWTH;
  endfunction

endpackage

// File: rtl/adder_tree_add8.sv
// Combinational unsigned sum of eight operands as a three-level binary tree.
module adder_tree_add8
  import adder_tree_pkg::*;
#(
  parameter int unsigned W = DEF_ADDER_WIDTH
) (
  input  logic [OPS_PER_REQ*W-1:0] i_ops,
  output logic [W+2:0]             o_sum
);

  logic [W:0]   w_l1 [4];
  logic [W+1:0] w_l2 [2];

  // Each level widens by one bit, so no carry is ever dropped.
  for (genvar g = 0; g < 4; g++) begin : g_l1
    assign w_l1[g] = {1'b0, i_ops[(2*g)*W +: W]} + {1'b0, i_ops[(2*g+1)*W +: W]};
  end

  for (genvar g = 0; g < 2; g++) begin : g_l2
    assign w_l2[g] = {1'b0, w_l1[2*g]} + {1'b0, w_l1[2*g+1]};
  end

  assign o_sum = {1'b0, w_l2[0]} + {1'b0, w_l2[1]};

endmodule

// File: rtl/adder_tree_arbiter.sv
// Round-robin arbiter feeding a two-stage adder-tree pipeline with a
// valid/ready result port; the whole pipeline freezes while a result waits.
module adder_tree_arbiter
  import adder_tree_pkg::*;
#(
  parameter  int unsigned ADDER_WIDTH = DEF_ADDER_WIDTH,
  parameter  int unsigned NUM_REQ     = DEF_NUM_REQ,
  localparam int unsigned ID_W        = id_width(NUM_REQ),
  localparam int unsigned SUM_W       = sum_width(ADDER_WIDTH),
  localparam int unsigned OPS_W       = OPS_PER_REQ * ADDER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_half,
  input  logic [NUM_REQ*OPS_W-1:0] req_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [SUM_W-1:0]         res_sum,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy,
  output logic [15:0]              op_count
);

  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_s1_vld;
  logic             r_s1_half;
  logic [ID_W-1:0]  r_s1_id;
  logic [OPS_W-1:0] r_s1_ops;
  logic             r_s2_vld;
  logic [SUM_W-1:0] r_s2_sum;
  logic [ID_W-1:0]  r_s2_id;
  logic [15:0]      r_op_count;

  logic             w_stall;
  logic             w_grant_vld;
  logic [ID_W-1:0]  w_grant_id;
  logic [OPS_W-1:0] w_tree_ops;
  logic [SUM_W-1:0] w_tree_sum;

  assign w_stall = r_s2_vld && !res_ready;

  // Search starts at r_rr_ptr and wraps; reset also suppresses any grant.
  always_comb begin
    int unsigned v_pos;
    // NOTE: every output gets a default before any branch, otherwise a
    // path that skips an assignment infers a latch.
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    req_ready   = '0;
    v_pos       = 0;
    if (rst_n && !w_stall) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        v_pos = 32'(r_rr_ptr) + i;
        if (v_pos >= NUM_REQ) v_pos = v_pos - NUM_REQ;
        if (!w_grant_vld && req_valid[v_pos[ID_W-1:0]]) begin
          w_grant_vld = 1'b1;
          w_grant_id  = v_pos[ID_W-1:0];
        end
      end
    end
    if (w_grant_vld) req_ready[w_grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_s1_vld   <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_id    <= '0;
      r_op_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (w_grant_vld)
        r_rr_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
      if (!w_stall) begin
        r_s1_vld <= w_grant_vld;
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_sum <= w_tree_sum;
          r_s2_id  <= r_s1_id;
        end
      end
      if (r_s2_vld && res_ready) r_op_count <= r_op_count + 16'd1;
    end
  end

  // NOTE: the operand register carries no reset; r_s1_vld qualifies it,
  // so clearing it would only add reset fan-out to a wide datapath.
  always_ff @(posedge clk) begin
    if (!w_stall && w_grant_vld) begin
      r_s1_ops  <= req_data[w_grant_id*OPS_W +: OPS_W];
      r_s1_id   <= w_grant_id;
      r_s1_half <= req_half[w_grant_id];
    end
  end

  always_comb begin
    w_tree_ops = r_s1_ops;
    if (r_s1_half) w_tree_ops[OPS_W-1:OPS_W/2] = '0;
  end

  adder_tree_add8 #(
    .W (ADDER_WIDTH)
  ) u_add8 (
    .i_ops (w_tree_ops),
    .o_sum (w_tree_sum)
  );

  assign res_valid = r_s2_vld;
  assign res_sum   = r_s2_sum;
  assign res_id    = r_s2_id;
  assign busy      = r_s1_vld || r_s2_vld;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Scoreboard bench: a cycle model of arbitration and pipeline occupancy
// queues expected sums at grant time and compares them as results leave.
module tb_adder_tree_arbiter;

  localparam int W   = 5;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int SW  = W + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_half = '0;
  logic [N*8*W-1:0]  req_data = '0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [SW-1:0]     res_sum;
  logic [IDW-1:0]    res_id;
  logic              busy;
  logic [15:0]       op_count;

  typedef struct {
    logic [SW-1:0]  sum;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t        sb_q[$];
  bit          m_s1, m_s2;
  int unsigned m_rr, m_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  adder_tree_arbiter #(
    .ADDER_WIDTH (W),
    .NUM_REQ     (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_half  (req_half),
    .req_data  (req_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_op(input int r, input int k, input logic [W-1:0] v);
    req_data[(r*8+k)*W +: W] = v;
  endtask

  function automatic logic [SW-1:0] exp_sum(input int r);
    int s = 0;
    int nk = req_half[r] ? 4 : 8;
    for (int k = 0; k < nk; k++) s += int'(req_data[(r*8+k)*W +: W]);
    return SW'(s);
  endfunction

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    bit           stall, g_vld;
    int           g_id;
    logic [N-1:0] exp_ready;
    exp_t         e;
    #1;
    stall = m_s2 && !res_ready;
    g_vld = 0;
    g_id  = 0;
    if (!stall) begin
      for (int i = 0; i < N; i++) begin
        int p;
        p = (int'(m_rr) + i) % N;
        if (!g_vld && req_valid[p]) begin
          g_vld = 1;
          g_id  = p;
        end
      end
    end
    exp_ready = '0;
    if (g_vld) exp_ready[g_id] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("res_valid", 32'(res_valid), 32'(m_s2));
    check("busy", 32'(busy), 32'(m_s1 || m_s2));
    check("op_count", 32'(op_count), 32'(m_cnt[15:0]));
    if (m_s2 && sb_q.size() > 0) begin
      check("res_sum", 32'(res_sum), 32'(sb_q[0].sum));
      check("res_id", 32'(res_id), 32'(sb_q[0].id));
    end
    e.sum = g_vld ? exp_sum(g_id) : '0;
    e.id  = IDW'(g_id);
    @(posedge clk);
    if (m_s2 && res_ready) begin
      sb_q.delete(0);
      m_cnt++;
    end
    if (!stall) begin
      m_s2 = m_s1;
      m_s1 = g_vld;
      if (g_vld) begin
        sb_q.push_back(e);
        m_rr = (g_id + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic randomize_data();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 8; k++) set_op(r, k, W'($urandom));
  endtask

  initial begin
    int unsigned k_pre;
    m_s1 = 0; m_s2 = 0; m_rr = 0; m_cnt = 0;
    req_valid = '1;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_sum", 32'(res_sum), 32'h0);
    check("rst_res_id", 32'(res_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_op_count", 32'(op_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Requester 0 alone, all operands at maximum, full mode.
    req_valid = 4'b0001;
    req_half  = '0;
    for (int k = 0; k < 8; k++) set_op(0, k, 5'd31);
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // Requester 2, half mode, operands 1..8.
    for (int k = 0; k < 8; k++) set_op(2, k, W'(k + 1));
    req_half  = 4'b0100;
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // Continuous requests from everyone, consumer always ready.
    randomize_data();
    req_half  = 4'b1010;
    req_valid = '1;
    repeat (12) cycle();

    // Consumer back-pressure for 5 cycles, then release.
    res_ready = 1'b0;
    repeat (5) cycle();
    res_ready = 1'b1;
    repeat (8) cycle();

    // Random traffic and back-pressure.
    for (int c = 0; c < 80; c++) begin
      randomize_data();
      req_valid = N'($urandom);
      req_half  = N'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (4) cycle();

    // Reset while both stages hold data.
    req_valid = '1;
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'h0);
    check("mid_rst_res_valid", 32'(res_valid), 32'h0);
    check("mid_rst_res_sum", 32'(res_sum), 32'h0);
    check("mid_rst_res_id", 32'(res_id), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_op_count", 32'(op_count), 32'h0);
    sb_q.delete();
    m_s1 = 0; m_s2 = 0; m_rr = 0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    repeat (3) cycle();
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // Preload the completion counter up to 0xFFFF, then wrap it.
    k_pre = 32'd65535 - (m_cnt % 32'd65536);
    req_valid = '1;
    for (int unsigned c = 0; c < k_pre; c++) cycle();
    req_valid = '0;
    repeat (4) cycle();
    check("op_count_full", 32'(op_count), 32'h0000_FFFF);
    req_valid = 4'b1000;
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    check("op_count_wrap", 32'(op_count), 32'h0);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
